da_shift_accumulator: RTL and testbench
=======================================

Name: da_shift_accumulator

Overview:
- Downstream stage of the parallel-LUT distributed-arithmetic datapath.
- Consumes one signed LUT partial sum per activation bit-plane, LSB plane first.
- Shift-accumulates DATA_WIDTH_A planes, subtracting the MSB plane when activations are two's complement, and emits one dot-product result per frame.
- Handshaked on both sides so the LUT/generator pair can stall or be stalled.

Parameters:
- K, 8, number of taps addressed by the LUT; sets the LUT sum width.
- DATA_WIDTH_B, 8, weight width inside the LUT.
- DATA_WIDTH_A, 8, activation width = bit-planes per frame (>=2).
- SIGNED_A, 1, 1 = activations two's complement (MSB plane subtracted); 0 = unsigned.
- LUT_W, DATA_WIDTH_B+$clog2(K)+1, LUT partial-sum width (derived, do not override).
- ACC_W, LUT_W+DATA_WIDTH_A, result width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort of partial frame; higher priority than in_valid.
- in_valid  in  1  lut_in carries the partial sum for plane plane_idx.
- in_ready  out  1  stage accepts a beat this cycle.
- lut_in  in  LUT_W  signed LUT partial sum.
- plane_idx  out  $clog2(DATA_WIDTH_A)  plane expected on next accepted beat.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- result  out  ACC_W  signed dot product.
- busy  out  1  frame partially accumulated (state ACCUM).

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, plane_idx=0, result=0, out_valid=0, busy=0. in_ready evaluates to 1. Reset mid-frame discards partial acc and any pending result.
- States:
  - IDLE: no partial frame.
  - ACCUM: planes 1..DATA_WIDTH_A-1 outstanding.
  - HOLD: result valid and awaiting acceptance.
- in_ready = (state != HOLD) || out_ready. This is combinational and allows a back-to-back frame start in the same cycle a result is taken.
- Beat accepted = in_valid && in_ready && !clear.
- term = sign_extend(lut_in, ACC_W) << plane_idx. Negate term when SIGNED_A=1 and plane_idx = DATA_WIDTH_A-1.
- IDLE + beat: acc<=term, plane_idx<=1, go ACCUM.
- ACCUM + beat, plane_idx < DATA_WIDTH_A-1: acc<=acc+term, plane_idx++.
- ACCUM + beat, plane_idx = DATA_WIDTH_A-1:
  - result<=acc+term, out_valid<=1, plane_idx<=0, acc<=0, go HOLD.
  - Latency: result is valid the cycle after the last plane beat.
- HOLD + out_ready: out_valid<=0, go IDLE. If a beat is accepted in the same cycle, it is treated as plane 0 of the new frame (go ACCUM).
- No beat (in_valid=0) in any state: acc, plane_idx and state hold.
- clear=1:
  - acc<=0, plane_idx<=0.
  - ACCUM goes to IDLE.
  - HOLD is unaffected: a pending result survives clear.
  - The in_valid beat in that cycle is dropped.
- Arithmetic: two's complement. ACC_W is sized so no overflow is possible for any lut_in sequence. No saturation logic.
- result changes only when a frame completes. It is stable while out_valid=1 and the value is retained after acceptance.
- plane_idx never exceeds DATA_WIDTH_A-1 and wraps to 0 only at frame completion or clear.

Test Plan (DATA_WIDTH_A=4, K=8, DATA_WIDTH_B=8 so LUT_W=12, ACC_W=16):
- SIGNED_A=1, lut_in 1,1,1,1 on consecutive cycles, out_ready=1 -> result=-1 (1+2+4-8), out_valid high exactly 1 cycle after 4th beat.
- SIGNED_A=0, same stimulus -> result=15. Then lut_in -2048 x4 -> result=-30720 (0x8800), no overflow.
- SIGNED_A=1, lut_in -2048 x4 -> result=+2048 (MSB subtraction of a negative LUT sum).
- Backpressure: out_ready=0 after a frame completes -> out_valid and result hold, in_ready=0. Raise out_ready together with in_valid (lut_in=3) -> result accepted, plane_idx=1, busy=1 next cycle.
- clear asserted after 2 planes (5,5) -> plane_idx=0, busy=0. A following frame of 2,0,0,0 -> result=2 with no residue.
- Async reset (rst=0) mid-ACCUM and while in HOLD -> all outputs return to reset values immediately without a clock edge. The next frame of 1,0,0,0 -> result=1.

Source files
------------

// File: rtl/da_shift_accumulator.sv
// Bit-serial shift-accumulator for the distributed-arithmetic datapath: folds one
// signed LUT partial sum per activation bit-plane (LSB first) into a dot product.
module da_shift_accumulator #(
  parameter int K            = 8,
  parameter int DATA_WIDTH_B = 8,
  parameter int DATA_WIDTH_A = 8,
  parameter int SIGNED_A     = 1,
  parameter int LUT_W        = DATA_WIDTH_B + $clog2(K) + 1,
  parameter int ACC_W        = LUT_W + DATA_WIDTH_A,
  localparam int IDX_W       = $clog2(DATA_WIDTH_A)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LUT_W-1:0]        lut_in,
  output logic [IDX_W-1:0]        plane_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH_A - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t                   state_reg, state_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic signed [ACC_W-1:0]  result_reg, result_next;

  logic                     ready_int;
  logic                     beat;
  logic                     last_plane;
  logic signed [ACC_W-1:0]  lut_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  term;

  // Acceptance depends on out_ready so a new frame can start as a result drains.
  assign ready_int  = (state_reg != HOLD) || out_ready;
  assign beat       = in_valid && ready_int && !clear;
  assign last_plane = (idx_reg == LAST_IDX);
  assign lut_ext    = {{(ACC_W - LUT_W){lut_in[LUT_W-1]}}, lut_in};
  assign shifted    = lut_ext << idx_reg;
  // The MSB plane of a two's-complement activation carries negative weight.
  assign term       = ((SIGNED_A != 0) && last_plane) ? -shifted : shifted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    result_next = result_reg;

    if (clear) begin
      acc_next = '0;
      idx_next = '0;
      if (state_reg == ACCUM) begin
        state_next = IDLE;
      end else if ((state_reg == HOLD) && out_ready) begin
        state_next = IDLE;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (beat) begin
            acc_next   = term;
            idx_next   = IDX_ONE;
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            if (last_plane) begin
              result_next = acc_reg + term;
              acc_next    = '0;
              idx_next    = '0;
              state_next  = HOLD;
            end else begin
              acc_next = acc_reg + term;
              idx_next = idx_reg + IDX_ONE;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (beat) begin
              acc_next   = term;
              idx_next   = IDX_ONE;
              state_next = ACCUM;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = ready_int;
    out_valid = (state_reg == HOLD);
    busy      = (state_reg == ACCUM);
    plane_idx = idx_reg;
    result    = result_reg;
  end

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Bench for da_shift_accumulator: a signed and an unsigned instance share one
// stimulus stream; results are checked against hand tables and a weighted-sum model.
module tb_da_shift_accumulator;

  localparam int N     = 4;
  localparam int LUT_W = 12;
  localparam int ACC_W = 16;

  typedef logic signed [LUT_W-1:0] frame_t [N];

  typedef struct {
    logic signed [LUT_W-1:0] p [N];
    longint exp_s;
    longint exp_u;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [LUT_W-1:0] lut_in = '0;

  logic s_in_ready, u_in_ready, s_out_valid, u_out_valid, s_busy, u_busy;
  logic [1:0] s_plane_idx, u_plane_idx;
  logic [ACC_W-1:0] s_result, u_result;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  da_shift_accumulator #(.K(8), .DATA_WIDTH_B(8), .DATA_WIDTH_A(N), .SIGNED_A(1)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .lut_in(lut_in), .plane_idx(s_plane_idx), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .busy(s_busy));

  da_shift_accumulator #(.K(8), .DATA_WIDTH_B(8), .DATA_WIDTH_A(N), .SIGNED_A(0)) dut_u (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(u_in_ready),
    .lut_in(lut_in), .plane_idx(u_plane_idx), .out_valid(u_out_valid),
    .out_ready(out_ready), .result(u_result), .busy(u_busy));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Dot product from its definition: plane i weighs 2^i, the top plane -2^(N-1) when signed.
  function automatic longint model(input frame_t p, input bit sgn);
    longint sum = 0;
    for (int i = 0; i < N; i++) begin
      longint w = longint'(1) << i;
      if (sgn && i == N - 1) w = -w;
      sum += longint'(p[i]) * w;
    end
    return sum;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [LUT_W-1:0] v);
    in_valid = 1'b1;
    lut_in = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string nm, input longint es, input longint eu);
    chk({nm, "_s_valid"}, longint'(s_out_valid), 1);
    chk({nm, "_u_valid"}, longint'(u_out_valid), 1);
    chk({nm, "_s_result"}, longint'($signed(s_result)), es);
    chk({nm, "_u_result"}, longint'($signed(u_result)), eu);
  endtask

  // Back-to-back frame with out_ready high; checks plane index per beat and one-cycle valid.
  task automatic run_frame(input string nm, input frame_t p, input longint es, input longint eu);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      lut_in = p[i];
      #1;
      chk({nm, "_plane_idx"}, longint'(s_plane_idx), i);
      tick();
    end
    in_valid = 1'b0;
    chk_result(nm, es, eu);
    tick();
    chk({nm, "_valid_drop"}, longint'(s_out_valid), 0);
    $display("frame %s: signed=%0d unsigned=%0d", nm, $signed(s_result), $signed(u_result));
  endtask

  vec_t vecs [6];
  frame_t fr;

  initial begin
    vecs[0].p = '{12'sd1, 12'sd1, 12'sd1, 12'sd1};          vecs[0].exp_s = -1;    vecs[0].exp_u = 15;
    vecs[1].p = '{-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048};
    vecs[1].exp_s = 2048; vecs[1].exp_u = -30720;
    vecs[2].p = '{12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047}; vecs[2].exp_s = -2047; vecs[2].exp_u = 30705;
    vecs[3].p = '{12'sd2, 12'sd0, 12'sd0, 12'sd0};          vecs[3].exp_s = 2;     vecs[3].exp_u = 2;
    vecs[4].p = '{12'sd0, 12'sd0, 12'sd0, -12'sd1};         vecs[4].exp_s = 8;     vecs[4].exp_u = -8;
    vecs[5].p = '{12'sd3, -12'sd5, 12'sd10, 12'sd1};        vecs[5].exp_s = 25;    vecs[5].exp_u = 41;

    // Reset state
    #3;
    chk("rst_valid", longint'(s_out_valid), 0);
    chk("rst_busy", longint'(s_busy), 0);
    chk("rst_in_ready", longint'(s_in_ready), 1);
    chk("rst_result", longint'(s_result), 0);
    chk("rst_plane_idx", longint'(u_plane_idx), 0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      fr = vecs[v].p;
      run_frame($sformatf("vec%0d", v), fr, vecs[v].exp_s, vecs[v].exp_u);
    end

    // Backpressure: result held with in_ready low, then accepted alongside a new frame start.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) beat(12'sd1);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      lut_in = 12'sd9;
      #1;
      chk("bp_in_ready", longint'(s_in_ready), 0);
      chk_result("bp_hold", -1, 15);
      tick();
    end
    out_ready = 1'b1;
    lut_in = 12'sd3;
    #1;
    chk("bp_in_ready_up", longint'(s_in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_valid_off", longint'(s_out_valid), 0);
    chk("bp_plane_idx", longint'(s_plane_idx), 1);
    chk("bp_busy", longint'(u_busy), 1);
    chk("bp_result_kept", longint'($signed(s_result)), -1);
    for (int i = 1; i < N; i++) beat(12'sd0);
    chk_result("bp_next", 3, 3);
    $display("frame backpressure: signed=%0d", $signed(s_result));
    tick();

    // Clear after two planes drops the partial sum and the coincident beat.
    beat(12'sd5);
    beat(12'sd5);
    clear = 1'b1;
    in_valid = 1'b1;
    lut_in = 12'sd77;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_plane_idx", longint'(s_plane_idx), 0);
    chk("clr_busy", longint'(s_busy), 0);
    fr = '{12'sd2, 12'sd0, 12'sd0, 12'sd0};
    run_frame("after_clear", fr, 2, 2);

    // Clear while a result is pending leaves it intact.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) beat(12'sd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_result("clr_hold", -1, 15);
    out_ready = 1'b1;
    tick();
    chk("clr_hold_drain", longint'(s_out_valid), 0);

    // Asynchronous reset mid-frame, without a clock edge.
    beat(12'sd7);
    beat(12'sd7);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_accum_busy", longint'(s_busy), 0);
    chk("arst_accum_idx", longint'(s_plane_idx), 0);
    chk("arst_accum_result", longint'(u_result), 0);
    rst = 1'b1;
    tick();
    // Asynchronous reset while a result waits.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) beat(12'sd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_hold_valid", longint'(s_out_valid), 0);
    chk("arst_hold_result", longint'(s_result), 0);
    chk("arst_hold_in_ready", longint'(s_in_ready), 1);
    rst = 1'b1;
    tick();
    fr = '{12'sd1, 12'sd0, 12'sd0, 12'sd0};
    run_frame("after_arst", fr, 1, 1);

    // Randomized frames with idle gaps and output stalls against the model.
    for (int f = 0; f < 30; f++) begin
      longint es, eu;
      for (int i = 0; i < N; i++) fr[i] = LUT_W'($urandom);
      es = model(fr, 1'b1);
      eu = model(fr, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          lut_in = LUT_W'($urandom);
          tick();
        end
        beat(fr[i]);
      end
      chk_result($sformatf("rnd%0d", f), es, eu);
      out_ready = 1'b0;
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) tick();
      chk($sformatf("rnd%0d_stable", f), longint'($signed(s_result)), es);
      out_ready = 1'b1;
      tick();
      $display("frame rnd%0d: signed=%0d unsigned=%0d", f, es, eu);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
